// File: rtl/popcount_pkg.sv
// popcount_pkg: shared widths, state type and clamp helper for the popcount path
package popcount_pkg;
  localparam int N = 5;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, EMIT} utx_state_t;
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c > CW'(N)) ? CW'(N) : c;
  endfunction
endpackage

// File: rtl/popcount_thermo_enc.sv
// popcount_thermo_enc: clamped count word to N-bit thermometer code with overflow flag
module popcount_thermo_enc
  import popcount_pkg::*;
(
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  thermo,
  output logic          ovf
);
  logic [CW-1:0] k;
  always_comb begin
    k = clamp_count(cnt);
    ovf = cnt > CW'(N);
    thermo = '0;
    for (int i = 0; i < N; i++) thermo[i] = CW'(i) < k;
  end
endmodule

// File: rtl/popcount05_unary_tx.sv
// popcount05_unary_tx: count word to N-bit unary serial stream, ones leading
module popcount05_unary_tx
  import popcount_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cnt_valid,
  output logic          cnt_ready,
  input  logic [CW-1:0] cnt_data,
  output logic          bit_valid,
  input  logic          bit_ready,
  output logic          bit_data,
  output logic          bit_last,
  output logic          sat_err
);
  utx_state_t state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d, thermo;
  logic [IW-1:0] idx_q, idx_d;
  logic sat_err_q, sat_err_d, ovf, beat, done, acc;
  popcount_thermo_enc u_enc (.cnt(cnt_data), .thermo(thermo), .ovf(ovf));
  assign bit_valid = state_q == EMIT;
  assign bit_data = shreg_q[0];
  assign bit_last = bit_valid && idx_q == IW'(N - 1);
  assign sat_err = sat_err_q;
  always_comb begin
    beat = bit_valid & bit_ready;
    done = beat & bit_last;
    cnt_ready = (state_q == IDLE) | done;
    acc = cnt_valid & cnt_ready;
    state_d = acc ? EMIT : done ? IDLE : state_q;
    shreg_d = acc ? thermo : beat ? shreg_q >> 1 : shreg_q;
    idx_d = (acc | done) ? '0 : beat ? idx_q + 1'b1 : idx_q;
    sat_err_d = acc & ovf;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      sat_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      sat_err_q <= sat_err_d;
    end
endmodule

// File: tb/tb_popcount05_unary_tx.sv
// tb_popcount05_unary_tx: directed table, back-to-back, backpressure, reset and loopback checks
module tb_popcount05_unary_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_valid = 1'b0;
  logic cnt_ready;
  logic [2:0] cnt_data = '0;
  logic bit_valid;
  logic bit_ready = 1'b0;
  logic bit_data;
  logic bit_last;
  logic sat_err;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [2:0] k;
    logic [4:0] bits;
    logic       sat;
  } vec_t;
  vec_t tbl[8];
  popcount05_unary_tx dut (
    .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .cnt_data(cnt_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_data(bit_data), .bit_last(bit_last), .sat_err(sat_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic send_word(input logic [2:0] k, input logic [4:0] eb, input logic es,
                           output logic [4:0] got_bits);
    cnt_valid = 1'b1;
    cnt_data = k;
    chk("cnt_ready_idle", cnt_ready, 1);
    @(negedge clk);
    cnt_valid = 1'b0;
    cnt_data = 3'($urandom_range(0, 7));
    chk("sat_err_pulse", sat_err, es);
    for (int i = 0; i < 5; i++) begin
      chk("bit_valid", bit_valid, 1);
      chk("bit_data", bit_data, eb[i]);
      chk("bit_last", bit_last, i == 4);
      got_bits[i] = bit_data;
      if (i > 0) chk("sat_err_clear", sat_err, 0);
      @(negedge clk);
    end
    chk("bit_valid_end", bit_valid, 0);
    chk("cnt_ready_end", cnt_ready, 1);
  endtask
  initial begin
    logic [4:0] got;
    logic [2:0] k;
    int n;
    int pc;
    int exp_pc;
    tbl[0] = '{3'd3, 5'b00111, 1'b0};
    tbl[1] = '{3'd0, 5'b00000, 1'b0};
    tbl[2] = '{3'd5, 5'b11111, 1'b0};
    tbl[3] = '{3'd7, 5'b11111, 1'b1};
    tbl[4] = '{3'd6, 5'b11111, 1'b1};
    tbl[5] = '{3'd1, 5'b00001, 1'b0};
    tbl[6] = '{3'd2, 5'b00011, 1'b0};
    tbl[7] = '{3'd4, 5'b01111, 1'b0};
    repeat (5) @(negedge clk);
    chk("rst_cnt_ready", cnt_ready, 1);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_data", bit_data, 0);
    chk("rst_bit_last", bit_last, 0);
    chk("rst_sat_err", sat_err, 0);
    rst_n = 1'b1;
    bit_ready = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 8; v++) send_word(tbl[v].k, tbl[v].bits, tbl[v].sat, got);
    cnt_valid = 1'b1;
    cnt_data = 3'd0;
    @(negedge clk);
    cnt_data = 3'd5;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_valid", bit_valid, 1);
      chk("b2b_data", bit_data, i >= 5);
      chk("b2b_last", bit_last, i == 4 || i == 9);
      if (i < 4) chk("b2b_ready_busy", cnt_ready, 0);
      if (i == 4) chk("b2b_ready_last", cnt_ready, 1);
      if (i == 5) cnt_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_idle", bit_valid, 0);
    bit_ready = 1'b0;
    cnt_valid = 1'b1;
    cnt_data = 3'd2;
    @(negedge clk);
    cnt_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      chk("bp_valid", bit_valid, 1);
      chk("bp_data", bit_data, n < 2);
      chk("bp_last", bit_last, n == 4);
      bit_ready = (c % 3) == 0;
      @(negedge clk);
      if (bit_ready) n++;
    end
    chk("bp_beats", n, 5);
    chk("bp_idle", bit_valid, 0);
    bit_ready = 1'b1;
    cnt_valid = 1'b1;
    cnt_data = 3'd4;
    @(negedge clk);
    cnt_valid = 1'b0;
    chk("mid_b1", bit_data, 1);
    @(negedge clk);
    chk("mid_b2", bit_data, 1);
    @(negedge clk);
    chk("mid_b3", bit_data, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bit_valid, 0);
    chk("mid_rst_ready", cnt_ready, 1);
    chk("mid_rst_data", bit_data, 0);
    chk("mid_rst_last", bit_last, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_quiet", bit_valid, 0);
    send_word(3'd1, 5'b00001, 1'b0, got);
    for (int r = 0; r < 20; r++) begin
      k = 3'($urandom_range(0, 7));
      exp_pc = (k > 3'd5) ? 5 : int'(k);
      send_word(k, 5'((1 << exp_pc) - 1), k > 3'd5, got);
      pc = 0;
      for (int b = 0; b < 5; b++) pc += int'(got[b]);
      chk("loop_popcount", pc, exp_pc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
